// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one operation at a time through
// the shared 16-bit ALU. It returns each result on a single tagged response channel.

// state | meaning
// IDLE  | no operation in flight; arbitrate and accept one request
// EXEC  | operands and control are stable at the ALU; capture its result at the edge
// RESP  | response held on rsp_*; wait for the rsp_valid/rsp_ready handshake
module alu_req_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [3:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        req1_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_s,
    input  logic        alu_ovf,
    input  logic        alu_zero,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_s,
    output logic        rsp_ovf,
    output logic        rsp_zero,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic [7:0]  gnt_cnt0,
    output logic [7:0]  gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   id_q;
    logic   gnt0;
    logic   gnt1;
    logic   op_illegal;

    // prio names the requester that wins when both are valid
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        case (alu_ctrl)
            4'd7, 4'd11, 4'd13, 4'd15: op_illegal = 1'b1;
            default:                   op_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            id_q      <= 1'b0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            alu_ctrl  <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= 16'h0000;
            rsp_ovf   <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            gnt_cnt0  <= 8'h00;
            gnt_cnt1  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        alu_a    <= gnt1 ? req1_a  : req0_a;
                        alu_b    <= gnt1 ? req1_b  : req0_b;
                        alu_ctrl <= gnt1 ? req1_op : req0_op;
                        id_q     <= gnt1;
                        prio     <= gnt0;
                        if (gnt0 && gnt_cnt0 != 8'hFF)
                            gnt_cnt0 <= gnt_cnt0 + 8'd1;
                        if (gnt1 && gnt_cnt1 != 8'hFF)
                            gnt_cnt1 <= gnt_cnt1 + 8'd1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // an illegal code reports a clean zero result, whatever the ALU drives
                    rsp_s     <= op_illegal ? 16'h0000 : alu_s;
                    rsp_ovf   <= op_illegal ? 1'b0     : alu_ovf;
                    rsp_zero  <= op_illegal ? 1'b1     : alu_zero;
                    rsp_err   <= op_illegal;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model and a behavioural ALU.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
    logic [3:0]  req0_op = 4'h0, req1_op = 4'h0;
    logic        req0_ready, req1_ready;
    logic [15:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_ctrl;
    logic        alu_ovf, alu_zero;
    logic        rsp_valid, rsp_id, rsp_ovf, rsp_zero, rsp_err;
    logic [15:0] rsp_s;
    logic        rsp_ready = 1'b0;
    logic [7:0]  gnt_cnt0, gnt_cnt1;

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_s(alu_s), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_ovf(rsp_ovf),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // returns {ovf, zero, s}; illegal codes drive garbage that the arbiter must ignore
    function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] s;
        logic        ovf;
        s   = 16'h0000;
        ovf = 1'b0;
        case (op)
            4'd0:  begin s = a - b; ovf = (a[15] != b[15]) && (s[15] != a[15]); end
            4'd1:  begin s = a + b; ovf = (a[15] == b[15]) && (s[15] != a[15]); end
            4'd2:  s = a | b;
            4'd3:  s = a & b;
            4'd4:  begin s = a - 16'd1; ovf = (a == 16'h8000); end
            4'd5:  begin s = a + 16'd1; ovf = (a == 16'h7FFF); end
            4'd6:  s = ~a;
            4'd8, 4'd12: s = a << b[3:0];
            4'd9:  s = {15'h0, $signed(a) < $signed(b)};
            4'd10: s = a >> b[3:0];
            4'd14: s = $signed(a) >>> b[3:0];
            default: begin s = 16'hBEEF; ovf = 1'b1; end
        endcase
        return {ovf, (s == 16'h0000), s};
    endfunction

    function automatic bit is_illegal(input logic [3:0] op);
        return (op == 4'd7) || (op == 4'd11) || (op == 4'd13) || (op == 4'd15);
    endfunction

    always_comb {alu_ovf, alu_zero, alu_s} = alu_fn(alu_ctrl, alu_a, alu_b);

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // transaction-level reference: one operation in flight, result visible two cycles
    // after the accept cycle, favoured requester flips to the one not just served
    bit          m_busy, m_rv, m_fav, m_id, m_rid, m_rovf, m_rzero, m_rerr;
    logic [15:0] m_a, m_b, m_rs;
    logic [3:0]  m_op;
    logic [7:0]  m_cnt0, m_cnt1;
    bit          last_g0, last_g1, s_rdy0, s_rdy1;

    task automatic model_reset();
        m_busy = 0; m_rv = 0; m_fav = 0; m_id = 0; m_rid = 0;
        m_rovf = 0; m_rzero = 0; m_rerr = 0;
        m_a = 16'h0; m_b = 16'h0; m_rs = 16'h0; m_op = 4'h0;
        m_cnt0 = 8'h0; m_cnt1 = 8'h0;
    endtask

    // called right after a falling edge: drive, check this cycle, advance the model
    task automatic step(input bit rn,
                        input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [3:0] op0,
                        input bit v1, input logic [15:0] a1, input logic [15:0] b1,
                        input logic [3:0] op1, input bit rr);
        bit          e0, e1;
        logic [17:0] r;
        rst_n = rn; rsp_ready = rr;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        #1;
        e0 = 0; e1 = 0;
        if (rn && !m_busy) begin
            if (v0 && (!v1 || !m_fav)) e0 = 1;
            else if (v1)               e1 = 1;
        end
        check("req0_ready", {15'h0, req0_ready}, {15'h0, e0});
        check("req1_ready", {15'h0, req1_ready}, {15'h0, e1});
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", {12'h0, alu_ctrl}, {12'h0, m_op});
        check("rsp_valid", {15'h0, rsp_valid}, {15'h0, m_rv});
        check("rsp_id", {15'h0, rsp_id}, {15'h0, m_rid});
        check("rsp_s", rsp_s, m_rs);
        check("rsp_ovf", {15'h0, rsp_ovf}, {15'h0, m_rovf});
        check("rsp_zero", {15'h0, rsp_zero}, {15'h0, m_rzero});
        check("rsp_err", {15'h0, rsp_err}, {15'h0, m_rerr});
        check("gnt_cnt0", {8'h0, gnt_cnt0}, {8'h0, m_cnt0});
        check("gnt_cnt1", {8'h0, gnt_cnt1}, {8'h0, m_cnt1});
        s_rdy0 = req0_ready; s_rdy1 = req1_ready;
        last_g0 = e0; last_g1 = e1;
        if (!rn) begin
            model_reset();
        end else if (m_busy && !m_rv) begin
            if (is_illegal(m_op)) begin
                m_rs = 16'h0; m_rovf = 0; m_rzero = 1; m_rerr = 1;
            end else begin
                r = alu_fn(m_op, m_a, m_b);
                m_rs = r[15:0]; m_rzero = r[16]; m_rovf = r[17]; m_rerr = 0;
            end
            m_rid = m_id;
            m_rv  = 1;
        end else if (m_rv && rr) begin
            m_rv = 0; m_busy = 0;
        end else if (e0 || e1) begin
            m_a  = e1 ? a1 : a0;
            m_b  = e1 ? b1 : b0;
            m_op = e1 ? op1 : op0;
            m_id = e1;
            m_fav = e0;
            if (e0 && m_cnt0 != 8'hFF) m_cnt0 = m_cnt0 + 8'd1;
            if (e1 && m_cnt1 != 8'hFF) m_cnt1 = m_cnt1 + 8'd1;
            m_busy = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 16'h0, 4'h0, rr);
    endtask

    task automatic do_reset();
        step(0, 0, 16'h0, 16'h0, 4'h0, 0, 16'h0, 16'h0, 4'h0, 0);
    endtask

    logic [15:0] obs_s;
    bit          obs_ovf, obs_zero, obs_err, obs_id;

    // one request from a single requester; records what sits on rsp_* in RESP,
    // then completes the handshake unless told to leave it pending
    task automatic txn(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input bit finish);
        int tries = 0;
        do begin
            if (id) step(1, 0, 16'h0, 16'h0, 4'h0, 1, a, b, op, 1);
            else    step(1, 1, a, b, op, 0, 16'h0, 16'h0, 4'h0, 1);
            tries++;
        end while (!(id ? s_rdy1 : s_rdy0) && tries < 8);
        if (tries >= 8) check("grant_timeout", 16'h0, 16'h1);
        idle(1, 1);
        obs_s = rsp_s; obs_ovf = rsp_ovf; obs_zero = rsp_zero; obs_err = rsp_err;
        obs_id = rsp_id;
        check("txn_rsp_valid", {15'h0, rsp_valid}, 16'h1);
        if (finish) idle(1, 1);
    endtask

    bit          p0_v, p1_v;
    logic [15:0] p0_a, p0_b, p1_a, p1_b;
    logic [3:0]  p0_op, p1_op;
    int          order[$];

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // reset values
        do_reset();
        idle(1, 1);

        // single add
        step(1, 1, 16'h0003, 16'h0004, 4'd1, 0, 16'h0, 16'h0, 4'h0, 1);
        check("add_ready_first", {15'h0, s_rdy0}, 16'h1);
        check("add_ctrl_exec", {12'h0, alu_ctrl}, 16'h1);
        idle(1, 1);
        check("add_rsp_valid", {15'h0, rsp_valid}, 16'h1);
        check("add_rsp_s", rsp_s, 16'h0007);
        check("add_rsp_id", {15'h0, rsp_id}, 16'h0);
        idle(1, 1);

        // contention from reset: 0,1,0,1
        do_reset();
        order.delete();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 16'h1111, 16'h0001, 4'd1, 1, 16'h2222, 16'h0002, 4'd2, 1);
            if (s_rdy0 && s_rdy1) check("both_ready", 16'h1, 16'h0);
            if (s_rdy0) order.push_back(0);
            if (s_rdy1) order.push_back(1);
        end
        check("rr_count", 16'(order.size()), 16'd4);
        for (int i = 0; i < order.size(); i++) check("rr_order", 16'(order[i]), 16'(i % 2));
        check("rr_cnt0", {8'h0, gnt_cnt0}, 16'd2);
        check("rr_cnt1", {8'h0, gnt_cnt1}, 16'd2);

        // overflow and zero passthrough
        txn(1, 16'h7FFF, 16'h0001, 4'd1, 1);
        check("ovf_s", obs_s, 16'h8000);
        check("ovf_flag", {15'h0, obs_ovf}, 16'h1);
        check("ovf_id", {15'h0, obs_id}, 16'h1);
        txn(1, 16'h0005, 16'h0005, 4'd0, 1);
        check("zero_s", obs_s, 16'h0000);
        check("zero_flag", {15'h0, obs_zero}, 16'h1);

        // illegal opcode with the ALU driving 0xBEEF
        txn(0, 16'h1234, 16'h5678, 4'd13, 1);
        check("ill_err", {15'h0, obs_err}, 16'h1);
        check("ill_s", obs_s, 16'h0000);
        check("ill_ovf", {15'h0, obs_ovf}, 16'h0);
        check("ill_zero", {15'h0, obs_zero}, 16'h1);

        // back-pressure with req1 waiting
        txn(0, 16'h0010, 16'h0001, 4'd10, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'h0, 16'h0, 4'h0, 1, 16'hAAAA, 16'h5555, 4'd3, 0);
            check("bp_s_stable", rsp_s, obs_s);
            check("bp_ready1", {15'h0, s_rdy1}, 16'h0);
        end
        step(1, 0, 16'h0, 16'h0, 4'h0, 1, 16'hAAAA, 16'h5555, 4'd3, 1);
        check("bp_hs_ready1", {15'h0, s_rdy1}, 16'h0);
        step(1, 0, 16'h0, 16'h0, 4'h0, 1, 16'hAAAA, 16'h5555, 4'd3, 1);
        check("bp_regrant", {15'h0, s_rdy1}, 16'h1);
        idle(2, 1);

        // reset while a response is held
        txn(1, 16'h0001, 16'h0002, 4'd1, 0);
        do_reset();
        idle(2, 1);
        check("rst_mid_valid", {15'h0, rsp_valid}, 16'h0);
        check("rst_mid_s", rsp_s, 16'h0);
        step(1, 1, 16'h0001, 16'h0001, 4'd1, 1, 16'h0002, 16'h0002, 4'd1, 1);
        check("rst_prio0", {15'h0, s_rdy0}, 16'h1);
        idle(2, 1);

        // saturation
        do_reset();
        for (int i = 0; i < 900; i++)
            step(1, 1, 16'(i), 16'h0003, 4'd5, 0, 16'h0, 16'h0, 4'h0, 1);
        check("sat_cnt0", {8'h0, gnt_cnt0}, 16'd255);
        idle(2, 1);

        // randomized traffic
        do_reset();
        p0_v = 0; p1_v = 0;
        p0_a = 0; p0_b = 0; p1_a = 0; p1_b = 0; p0_op = 0; p1_op = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0_v) begin
                p0_v = ($urandom_range(0, 2) != 0);
                p0_a = 16'($urandom); p0_b = 16'($urandom); p0_op = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) p0_v = 0;
            if (!p1_v) begin
                p1_v = ($urandom_range(0, 2) != 0);
                p1_a = 16'($urandom); p1_b = 16'($urandom); p1_op = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) p1_v = 0;
            step(($urandom_range(0, 199) != 0), p0_v, p0_a, p0_b, p0_op,
                 p1_v, p1_a, p1_b, p1_op, ($urandom_range(0, 9) < 7));
            if (last_g0) p0_v = 0;
            if (last_g1) p1_v = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
